// File: rtl/fd_skid_if.sv
// -----------------------------------------------------------------------------
// fd_skid_if
// Handshake and payload bundle between fetch, the fetch-to-decode skid stage
// and decode.
//   Upstream : in_valid, in_ready, instr_i, pc8_i, bd_i, exc_i
//   Downstream: out_valid, out_ready, instr_d, pc8_d, bd_d, exc_d
//   Status   : count (occupancy 0..2)
// Modports:
//   slave  - the skid stage itself (consumes upstream, produces downstream)
//   master - the surrounding environment (fetch + decode)
// -----------------------------------------------------------------------------
interface fd_skid_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int EXC_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_i;
  logic [PC_W-1:0]    pc8_i;
  logic               bd_i;
  logic [EXC_W-1:0]   exc_i;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc8_d;
  logic               bd_d;
  logic [EXC_W-1:0]   exc_d;

  logic [1:0]         count;

  modport slave (
    input  in_valid, instr_i, pc8_i, bd_i, exc_i, out_ready,
    output in_ready, out_valid, instr_d, pc8_d, bd_d, exc_d, count
  );

  modport master (
    output in_valid, instr_i, pc8_i, bd_i, exc_i, out_ready,
    input  in_ready, out_valid, instr_d, pc8_d, bd_d, exc_d, count
  );
endinterface

// File: rtl/fd_skid_stage.sv
// -----------------------------------------------------------------------------
// fd_skid_stage
// Fetch-to-decode pipeline stage built as a 2-entry skid buffer with
// valid/ready on both sides. When empty it presents a NOP bubble whose pc8_d
// is always defined, so downstream exception logic has an EPC source.
// Ports:
//   clk    - clock, all state on rising edge
//   clr_n  - synchronous active-low reset
//   flush  - exception flush (empties stage, bubble pc8 = FLUSH_PC8)
//   eret   - ERET redirect (empties stage, bubble pc8 = npc + 8)
//   npc    - ERET target PC
//   bus    - fd_skid_if slave: upstream/downstream handshake, payload, count
// -----------------------------------------------------------------------------
module fd_skid_stage #(
  parameter int              INSTR_W   = 32,
  parameter int              PC_W      = 32,
  parameter int              EXC_W     = 5,
  parameter logic [PC_W-1:0] RESET_PC8 = 32'h0000_3008,
  parameter logic [PC_W-1:0] FLUSH_PC8 = 32'h0000_3008
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            flush,
  input  logic            eret,
  input  logic [PC_W-1:0] npc,
  fd_skid_if.slave        bus
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc8;
    logic               bd;
    logic [EXC_W-1:0]   exc;
  } entry_t;

  entry_t          slot0_q, slot0_d;
  entry_t          slot1_q, slot1_d;
  logic [PC_W-1:0] bubble_pc8_q, bubble_pc8_d;
  logic [1:0]      count_q, count_d;

  entry_t          in_entry;
  logic            push;
  logic            pop;
  logic            in_ready_w;
  logic            out_valid_w;

  assign in_entry    = '{instr: bus.instr_i, pc8: bus.pc8_i, bd: bus.bd_i, exc: bus.exc_i};
  // Both handshake flags decode straight from the count flop.
  assign in_ready_w  = (count_q != 2'd2);
  assign out_valid_w = (count_q != 2'd0);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  always_comb begin
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    bubble_pc8_d = bubble_pc8_q;
    count_d      = count_q;
    if (flush) begin
      count_d      = 2'd0;
      bubble_pc8_d = FLUSH_PC8;
    end else if (eret) begin
      count_d      = 2'd0;
      bubble_pc8_d = npc + PC_W'(8);   // wraps mod 2^PC_W
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            slot0_d = in_entry;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b10: begin
              slot1_d = in_entry;
              count_d = 2'd2;
            end
            2'b01: begin
              // Going empty: the bubble inherits the departing PC+8.
              count_d      = 2'd0;
              bubble_pc8_d = slot0_q.pc8;
            end
            2'b11: slot0_d = in_entry;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            slot0_d = slot1_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      slot0_q      <= '0;
      slot1_q      <= '0;
      bubble_pc8_q <= RESET_PC8;
      count_q      <= 2'd0;
    end else begin
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      bubble_pc8_q <= bubble_pc8_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.count     = count_q;
  assign bus.instr_d   = out_valid_w ? slot0_q.instr : '0;
  assign bus.pc8_d     = out_valid_w ? slot0_q.pc8   : bubble_pc8_q;
  assign bus.bd_d      = out_valid_w ? slot0_q.bd    : 1'b0;
  assign bus.exc_d     = out_valid_w ? slot0_q.exc   : '0;

endmodule

// File: tb/tb_fd_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_fd_skid_stage
// Self-checking bench for fd_skid_stage: a queue-based reference model of the
// stage, directed scenarios with literal expectations, then random traffic.
// -----------------------------------------------------------------------------
module tb_fd_skid_stage;

  logic        clk = 1'b0;
  logic        clr_n;
  logic        flush;
  logic        eret;
  logic [31:0] npc;

  fd_skid_if #(.INSTR_W(32), .PC_W(32), .EXC_W(5)) bus ();

  fd_skid_stage #(
    .INSTR_W(32), .PC_W(32), .EXC_W(5),
    .RESET_PC8(32'h0000_3008), .FLUSH_PC8(32'h0000_3008)
  ) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .flush(flush),
    .eret (eret),
    .npc  (npc),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        bd;
    logic [4:0]  exc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mbub;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current state.
  task automatic compare_all();
    int sz;
    sz = mq.size();
    chk("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    chk("in_ready",  64'(bus.in_ready),  64'(sz != 2));
    chk("count",     64'(bus.count),     64'(sz));
    if (sz != 0) begin
      chk("instr_d", 64'(bus.instr_d), 64'(mq[0].instr));
      chk("pc8_d",   64'(bus.pc8_d),   64'(mq[0].pc8));
      chk("bd_d",    64'(bus.bd_d),    64'(mq[0].bd));
      chk("exc_d",   64'(bus.exc_d),   64'(mq[0].exc));
    end else begin
      chk("instr_d", 64'(bus.instr_d), 64'd0);
      chk("pc8_d",   64'(bus.pc8_d),   64'(mbub));
      chk("bd_d",    64'(bus.bd_d),    64'd0);
      chk("exc_d",   64'(bus.exc_d),   64'd0);
    end
  endtask

  // One clock: drive inputs (called at a negedge), advance the model, then
  // check outputs at the following negedge.
  task automatic step(input logic rn, input logic fl, input logic er, input logic [31:0] np,
                      input logic iv, input logic [31:0] ins, input logic [31:0] p8,
                      input logic b, input logic [4:0] ex, input logic ordy);
    logic push, pop;
    ent_t e, popped;
    clr_n         = rn;
    flush         = fl;
    eret          = er;
    npc           = np;
    bus.in_valid  = iv;
    bus.instr_i   = ins;
    bus.pc8_i     = p8;
    bus.bd_i      = b;
    bus.exc_i     = ex;
    bus.out_ready = ordy;

    push = iv && (mq.size() != 2);
    pop  = ordy && (mq.size() != 0);
    if (!rn) begin
      mq.delete();
      mbub = 32'h0000_3008;
    end else if (fl) begin
      mq.delete();
      mbub = 32'h0000_3008;
    end else if (er) begin
      mq.delete();
      mbub = np + 32'd8;
    end else begin
      popped = '{instr: '0, pc8: '0, bd: 1'b0, exc: '0};
      if (pop) popped = mq.pop_front();
      if (push) begin
        e = '{instr: ins, pc8: p8, bd: b, exc: ex};
        mq.push_back(e);
      end
      if (pop && mq.size() == 0) mbub = popped.pc8;
    end

    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] p8, input logic ordy);
    step(1, 0, 0, 0, 1, ins, p8, 0, 0, ordy);
  endtask

  task automatic idle(input logic ordy);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  initial begin
    mbub = 32'h0000_3008;
    clr_n = 0; flush = 0; eret = 0; npc = 0;
    bus.in_valid = 0; bus.instr_i = 0; bus.pc8_i = 0; bus.bd_i = 0;
    bus.exc_i = 0; bus.out_ready = 0;
    @(negedge clk);

    // Reset with upstream valid asserted
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h1234, 1, 5'd3, 1);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'h1234, 1, 5'd3, 1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_pc8",       64'(bus.pc8_d),     64'h3008);
    chk("rst_instr",     64'(bus.instr_d),   64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Streaming with downstream always ready
    push1(32'h2401_0001, 32'h3008, 1);
    chk("s1_instr", 64'(bus.instr_d), 64'h2401_0001);
    chk("s1_count", 64'(bus.count), 64'd1);
    push1(32'h2402_0002, 32'h300C, 1);
    chk("s2_instr", 64'(bus.instr_d), 64'h2402_0002);
    push1(32'h2403_0003, 32'h3010, 1);
    chk("s3_instr", 64'(bus.instr_d), 64'h2403_0003);
    chk("s3_count", 64'(bus.count), 64'd1);
    idle(1);
    chk("s_empty_pc8", 64'(bus.pc8_d), 64'h3010);

    // Skid: downstream stalled, third entry must wait upstream
    push1(32'hA, 32'h4008, 0);
    push1(32'hB, 32'h400C, 0);
    chk("skid_count", 64'(bus.count), 64'd2);
    chk("skid_in_ready", 64'(bus.in_ready), 64'd0);
    push1(32'hC, 32'h4010, 0);
    chk("skid_hold_instr", 64'(bus.instr_d), 64'hA);
    push1(32'hC, 32'h4010, 1);
    chk("skid_drain_b", 64'(bus.instr_d), 64'hB);
    chk("skid_drain_cnt", 64'(bus.count), 64'd1);
    push1(32'hC, 32'h4010, 1);
    chk("skid_drain_c", 64'(bus.instr_d), 64'hC);
    idle(1);

    // ERET from full, normal target and wrapping target
    push1(32'h11, 32'h5008, 0);
    push1(32'h12, 32'h500C, 0);
    step(1, 0, 1, 32'h0000_3100, 1, 32'h13, 32'h5010, 0, 0, 1);
    chk("eret_count", 64'(bus.count), 64'd0);
    chk("eret_valid", 64'(bus.out_valid), 64'd0);
    chk("eret_instr", 64'(bus.instr_d), 64'd0);
    chk("eret_pc8",   64'(bus.pc8_d), 64'h3108);
    push1(32'h11, 32'h5008, 0);
    push1(32'h12, 32'h500C, 0);
    step(1, 0, 1, 32'hFFFF_FFFC, 1, 32'h13, 32'h5010, 0, 0, 1);
    chk("eret_wrap_pc8", 64'(bus.pc8_d), 64'h4);

    // Flush beats eret, push+pop discarded
    push1(32'h21, 32'h6008, 0);
    step(1, 1, 1, 32'h0000_7000, 1, 32'h22, 32'h600C, 0, 0, 1);
    chk("flush_pc8",   64'(bus.pc8_d), 64'h3008);
    chk("flush_count", 64'(bus.count), 64'd0);
    idle(1);
    chk("flush_no_entry", 64'(bus.out_valid), 64'd0);

    // Drain to empty: bubble keeps pc8 but clears bd/exc
    step(1, 0, 0, 0, 1, 32'h31, 32'h3014, 1, 5'd10, 0);
    chk("drain_exc_held", 64'(bus.exc_d), 64'd10);
    idle(1);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_pc8",   64'(bus.pc8_d), 64'h3014);
    chk("drain_exc",   64'(bus.exc_d), 64'd0);
    chk("drain_bd",    64'(bus.bd_d), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0),
           $urandom,
           ($urandom_range(0, 3) != 0),
           $urandom, $urandom,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
